// File: rtl/mem_store_buffer.sv
// Store write buffer and load sequencer in front of the data memory.
// Stores drain one per cycle from a small FIFO; loads issue only when the FIFO is empty.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 14
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [5:0]               req_op,
  input  logic [AW-1:0]            req_addr,
  input  logic [31:0]              req_wdata,
  input  logic [31:0]              req_pc,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     dm_we,
  output logic [AW-1:0]            dm_addr,
  output logic [31:0]              dm_din,
  output logic [5:0]               dm_op,
  output logic [31:0]              dm_pc,
  input  logic [31:0]              dm_dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [5:0]    op;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   pc;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;

  logic   push, pop, load_acc;
  entry_t head;

  assign full  = (count_q == DEPTH_C);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign req_ready = !rst && (req_we ? !full : empty);
  assign push      = req_valid && req_ready && req_we;
  assign load_acc  = req_valid && req_ready && !req_we;
  assign pop       = !empty && !rst;

  // A load is only ever accepted when empty, so it never competes with a drain.
  always_comb begin
    dm_we   = 1'b0;
    dm_addr = '0;
    dm_din  = '0;
    dm_op   = '0;
    dm_pc   = '0;
    if (pop) begin
      dm_we   = 1'b1;
      dm_addr = head.addr;
      dm_din  = head.wdata;
      dm_op   = head.op;
      dm_pc   = head.pc;
    end else if (load_acc) begin
      dm_addr = req_addr;
      dm_op   = req_op;
      dm_pc   = req_pc;
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{op: req_op, addr: req_addr, wdata: req_wdata, pc: req_pc};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    rsp_valid_d = load_acc;
    rsp_rdata_d = load_acc ? dm_dout : rsp_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Entry storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule
